// File: rtl/cpu_mem_bus_ctrl.sv
// Single-outstanding CPU-to-memory bus controller: accepts one request, issues it to
// the memory honouring its stall, captures synchronous read data and returns one response.
module cpu_mem_bus_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int STALL_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic              req_sz,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata_8,
  output logic [15:0]       mem_wdata_16,
  output logic              mem_acc_sz,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata_8,
  input  logic [15:0]       mem_rdata_16,
  input  logic              mem_stall,
  output logic              err_sticky
);

  localparam logic       SZ_8  = 1'b0;
  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic                sz_q;
  logic [15:0]         wdata_q;
  logic [7:0]          stall_cnt_q;
  logic [7:0]          stall_cnt_d;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [15:0]         resp_rdata_q;
  logic                resp_err_q;
  logic                mem_we_q;
  logic                err_sticky_q;

  // Saturating count of stalled ISSUE cycles
  assign stall_cnt_d = (stall_cnt_q == LIMIT) ? stall_cnt_q : stall_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      sz_q         <= 1'b0;
      wdata_q      <= 16'h0000;
      stall_cnt_q  <= 8'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 16'h0000;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            we_q        <= req_we;
            sz_q        <= req_sz;
            wdata_q     <= req_wdata;
            stall_cnt_q <= 8'd0;
            mem_we_q    <= req_we;
            req_ready_q <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_stall) begin
            mem_we_q <= 1'b0;
            if (we_q) begin
              resp_rdata_q <= 16'h0000;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              state_q <= CAPTURE;
            end
          end else begin
            stall_cnt_q <= stall_cnt_d;
            if (stall_cnt_d == LIMIT) begin
              // Watchdog abort: drop the write strobe before memory ever sees it unstalled
              mem_we_q     <= 1'b0;
              resp_rdata_q <= 16'h0000;
              resp_err_q   <= 1'b1;
              err_sticky_q <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        CAPTURE: begin
          resp_rdata_q <= (sz_q == SZ_8) ? {8'h00, mem_rdata_8} : mem_rdata_16;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign err_sticky   = err_sticky_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign mem_acc_sz   = sz_q;
  assign mem_wdata_8  = wdata_q[7:0];
  assign mem_wdata_16 = wdata_q;

endmodule

// File: tb/tb_cpu_mem_bus_ctrl.sv
// Scoreboard bench for cpu_mem_bus_ctrl: a byte-array memory with pair byte order
// (high byte at the lower address), stall patterns, and a reference model of responses.
`timescale 1ns/1ps
module tb_cpu_mem_bus_ctrl;
  localparam int   LIMIT = 8;
  localparam logic SZ8   = 1'b0;
  localparam logic SZ16  = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = 16'h0;
  logic        req_we = 1'b0;
  logic        req_sz = 1'b0;
  logic [15:0] req_wdata = 16'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata_8;
  logic [15:0] mem_wdata_16;
  logic        mem_acc_sz;
  logic        mem_we;
  logic [7:0]  mem_rdata_8 = 8'h0;
  logic [15:0] mem_rdata_16 = 16'h0;
  logic        mem_stall = 1'b0;
  logic        err_sticky;

  cpu_mem_bus_ctrl #(.ADDR_W(16), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_sz(req_sz), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata_8(mem_wdata_8), .mem_wdata_16(mem_wdata_16),
    .mem_acc_sz(mem_acc_sz), .mem_we(mem_we),
    .mem_rdata_8(mem_rdata_8), .mem_rdata_16(mem_rdata_16), .mem_stall(mem_stall),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int stall_mode = 0;      // 0: never stall, 1: always stall, 2: toggle each cycle
  int commit_cnt = 0;
  int done_cnt = 0;
  int txn_no = 0;
  logic [7:0]  bmem  [0:65535];
  logic [7:0]  model [0:65535];
  logic        stall_hist [0:8191];
  logic [15:0] last_rdata = 16'h0;
  logic        last_err = 1'b0;
  int          last_lat = 0;

  typedef struct {
    logic        we;
    logic        sz;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          acc;
    int          commit0;
  } txn_t;
  txn_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Cycle counter and memory-side stall generator
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (stall_mode)
        0: mem_stall = 1'b0;
        1: mem_stall = 1'b1;
        default: mem_stall = ~mem_stall;
      endcase
    end
  end

  // Memory with synchronous read, write performed only when not stalled
  initial begin
    logic [7:0]  v;
    logic [15:0] sa, a1, s16;
    logic [7:0]  s8;
    logic        sw, ssz;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      bmem[i]  = v;
      model[i] = v;
    end
    forever begin
      @(negedge clk);
      sa = mem_addr; sw = mem_we && !mem_stall; ssz = mem_acc_sz;
      s8 = mem_wdata_8; s16 = mem_wdata_16;
      @(posedge clk);
      #1;
      a1 = sa + 16'd1;
      mem_rdata_8  = bmem[sa];
      mem_rdata_16 = {bmem[sa], bmem[a1]};
      if (sw) begin
        if (ssz == SZ16) begin
          bmem[sa] = s16[15:8];
          bmem[a1] = s16[7:0];
        end else begin
          bmem[sa] = s8;
        end
      end
    end
  end

  // Monitor: accepts push onto the scoreboard, responses pop and compare
  initial begin
    txn_t        t;
    int          k, issue_cyc, lat_exp, we_cycles, we_rises;
    logic        err_exp, prev_valid, prev_we;
    logic [15:0] rd_exp, a1, held_rdata;
    logic        held_err;
    we_cycles = 0; we_rises = 0; prev_valid = 1'b0; prev_we = 1'b0;
    held_rdata = 16'h0; held_err = 1'b0;
    forever begin
      @(negedge clk);
      stall_hist[cyc % 8192] = mem_stall;
      if (mem_we) we_cycles++;
      if (mem_we && !prev_we) we_rises++;
      if (mem_we && !mem_stall) commit_cnt++;
      prev_we = mem_we;
      if (reset) begin
        sb.delete();
        prev_valid = 1'b0;
      end else begin
        if (req_valid && req_ready) begin
          t.we = req_we; t.sz = req_sz; t.addr = req_addr; t.wdata = req_wdata;
          t.acc = cyc; t.commit0 = commit_cnt;
          sb.push_back(t);
          we_cycles = 0; we_rises = 0;
        end
        if (resp_valid && !prev_valid) begin
          if (sb.size() == 0) begin
            chk("orphan_resp", 32'(resp_valid), 32'd0);
          end else begin
            t = sb.pop_front();
            k = 0;
            while (k < LIMIT && stall_hist[(t.acc + 1 + k) % 8192]) k++;
            err_exp   = (k >= LIMIT);
            issue_cyc = err_exp ? LIMIT : k + 1;
            lat_exp   = issue_cyc + 1 + ((!t.we && !err_exp) ? 1 : 0);
            a1 = t.addr + 16'd1;
            rd_exp = 16'h0;
            if (!err_exp && !t.we)
              rd_exp = (t.sz == SZ16) ? {model[t.addr], model[a1]} : {8'h00, model[t.addr]};
            if (!err_exp && t.we) begin
              if (t.sz == SZ16) begin
                model[t.addr] = t.wdata[15:8];
                model[a1]     = t.wdata[7:0];
              end else begin
                model[t.addr] = t.wdata[7:0];
              end
            end
            chk("latency", 32'(cyc - t.acc), 32'(lat_exp));
            chk("resp_rdata", 32'(resp_rdata), 32'(rd_exp));
            chk("resp_err", 32'(resp_err), 32'(err_exp));
            chk("we_cycles", 32'(we_cycles), t.we ? 32'(issue_cyc) : 32'd0);
            chk("we_pulses", 32'(we_rises), t.we ? 32'd1 : 32'd0);
            chk("commits", 32'(commit_cnt - t.commit0), (t.we && !err_exp) ? 32'd1 : 32'd0);
            held_rdata = resp_rdata; held_err = resp_err;
            last_rdata = resp_rdata; last_err = resp_err; last_lat = cyc - t.acc;
            txn_no++;
            $display("txn %0d: %s sz%0d addr=%h wdata=%h -> rdata=%h err=%b lat=%0d",
                     txn_no, t.we ? "WR" : "RD", (t.sz == SZ16) ? 16 : 8, t.addr, t.wdata,
                     resp_rdata, resp_err, cyc - t.acc);
          end
        end else if (resp_valid && prev_valid) begin
          chk("hold_rdata", 32'(resp_rdata), 32'(held_rdata));
          chk("hold_err", 32'(resp_err), 32'(held_err));
        end
        if (resp_valid && resp_ready) done_cnt++;
        prev_valid = resp_valid;
      end
    end
  end

  // Present a request and wait for it to be accepted; called at posedge+1
  task automatic issue_req(input logic we, input logic sz, input logic [15:0] addr, input logic [15:0] wdata);
    bit ok = 0;
    req_valid = 1'b1; req_we = we; req_sz = sz; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom); req_sz = 1'($urandom);
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int d0, input bit rnd);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done_cnt != d0) ok = 1;
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    chk("resp_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send(input logic we, input logic sz, input logic [15:0] addr, input logic [15:0] wdata, input bit rnd);
    int d0 = done_cnt;
    issue_req(we, sz, addr, wdata);
    wait_done(d0, rnd);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int d0, c0;
    bit ok;
    step(3);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_resp_valid", 32'(resp_valid), 32'd0);
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      chk("idle_err_sticky", 32'(err_sticky), 32'd0);
      @(posedge clk); #1;
    end

    // Directed accesses, no stall
    stall_mode = 0;
    send(1'b1, SZ16, 16'h0010, 16'hBEEF, 0);
    chk("wr_lat", 32'(last_lat), 32'd2);
    send(1'b0, SZ16, 16'h0010, 16'h0000, 0);
    chk("rd16_beef", 32'(last_rdata), 32'h0000BEEF);
    chk("rd_lat", 32'(last_lat), 32'd3);
    send(1'b1, SZ8, 16'h0011, 16'h775A, 0);
    send(1'b0, SZ8, 16'h0011, 16'h0000, 0);
    chk("rd8_5a", 32'(last_rdata), 32'h0000005A);
    send(1'b0, SZ16, 16'h0010, 16'h0000, 0);
    chk("rd16_be5a", 32'(last_rdata), 32'h0000BE5A);
    send(1'b1, SZ16, 16'h0013, 16'hC0DE, 0);
    send(1'b0, SZ16, 16'h0013, 16'h0000, 0);
    chk("rd16_odd", 32'(last_rdata), 32'h0000C0DE);
    send(1'b1, SZ16, 16'hFFFF, 16'hA1B2, 0);
    send(1'b0, SZ16, 16'hFFFF, 16'h0000, 0);
    chk("rd16_ffff", 32'(last_rdata), 32'h0000A1B2);

    // Random traffic against a toggling stall and random response back-pressure
    stall_mode = 2;
    for (int n = 0; n < 20; n++) begin
      send(1'($urandom), 1'($urandom),
           ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'(16'h0010 + $urandom_range(0, 7)),
           16'($urandom), 1);
    end

    // Permanent stall: watchdog abort, write suppressed
    stall_mode = 1;
    step(2);
    send(1'b1, SZ16, 16'h0012, 16'h1234, 0);
    chk("abort_err", 32'(last_err), 32'd1);
    chk("abort_lat", 32'(last_lat), 32'(LIMIT + 1));
    chk("abort_rdata", 32'(last_rdata), 32'd0);
    chk("abort_sticky", 32'(err_sticky), 32'd1);
    stall_mode = 0;
    step(2);
    send(1'b0, SZ16, 16'h0012, 16'h0000, 0);
    chk("post_abort_err", 32'(last_err), 32'd0);
    chk("sticky_kept", 32'(err_sticky), 32'd1);

    // Held response, then reset in the middle of a stalled write
    resp_ready = 1'b0;
    d0 = done_cnt;
    issue_req(1'b0, SZ8, 16'h0015, 16'h0000);
    resp_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (resp_valid) ok = 1;
      @(posedge clk); #1;
    end
    chk("hold_reach_resp", 32'(ok), 32'd1);
    step(4);
    wait_done(d0, 0);
    stall_mode = 1;
    step(2);
    c0 = commit_cnt;
    resp_ready = 1'b0;
    issue_req(1'b1, SZ16, 16'h0014, 16'h5555);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    stall_mode = 0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata8", 32'(mem_wdata_8), 32'd0);
    chk("rst_mem_wdata16", 32'(mem_wdata_16), 32'd0);
    chk("rst_mem_acc_sz", 32'(mem_acc_sz), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_resp", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("rst_no_write", 32'(commit_cnt - c0), 32'd0);
    send(1'b0, SZ16, 16'h0014, 16'h0000, 0);

    // Memory contents must agree with the reference model
    for (int a = 0; a < 32; a++)
      chk("mem_contents", 32'(bmem[a]), 32'(model[a]));
    chk("mem_contents_ffff", 32'(bmem[65535]), 32'(model[65535]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
